// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: core handshake and RAM data-port bundle for mem_access_ctrl
// slave  : the controller (drives busy/ack/err/rdata and the RAM request signals)
// master : the core plus RAM model (drives req/we/size/unsigned/addr/wdata and ram_rdata_i)
interface mem_access_ctrl_if;
    logic        req_i;
    logic        we_i;
    logic [1:0]  size_i;
    logic        unsigned_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        busy_o;
    logic        ack_o;
    logic        err_o;
    logic [31:0] rdata_o;
    logic        ram_ce_o;
    logic        ram_we_o;
    logic [31:0] ram_addr_o;
    logic [31:0] ram_wdata_o;
    logic [31:0] ram_rdata_i;
    modport slave (
        input  req_i, we_i, size_i, unsigned_i, addr_i, wdata_i, ram_rdata_i,
        output busy_o, ack_o, err_o, rdata_o, ram_ce_o, ram_we_o, ram_addr_o, ram_wdata_o
    );
    modport master (
        output req_i, we_i, size_i, unsigned_i, addr_i, wdata_i, ram_rdata_i,
        input  busy_o, ack_o, err_o, rdata_o, ram_ce_o, ram_we_o, ram_addr_o, ram_wdata_o
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: byte/half/word load-store controller in front of a word-only RAM port
// Ports:
//   clk_i  - clock, all state on rising edge
//   rst_ni - asynchronous active-low reset
//   bus    - mem_access_ctrl_if.slave: core req/busy/ack/err/rdata handshake and RAM
//            ce/we/addr/wdata/rdata port (big-endian lanes, byte 0 in [31:24])
// Optional: define MEMCTRL_MISALIGN_TRAP_EN to complete misaligned half/word accesses
//           as an error ack without touching the RAM; otherwise err_o is always 0.
module mem_access_ctrl #(
    parameter int RAM_ADDR_WIDTH = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    mem_access_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, WRITE} state_t;

    localparam logic [31:0] L_ADDR_MASK = (RAM_ADDR_WIDTH >= 32) ? 32'hFFFF_FFFF :
                                          32'((64'd1 << RAM_ADDR_WIDTH) - 64'd1);

    state_t      r_state;
    logic        r_ack;
    logic        r_err;
    logic [31:0] r_rdata;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_uns;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

    logic        w_mis;
    logic [4:0]  w_sh;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_bmask;
    logic [31:0] w_load;
    logic [31:0] w_merge;

`ifdef MEMCTRL_MISALIGN_TRAP_EN
    assign w_mis = (bus.size_i == 2'd1 && bus.addr_i[0]) || (bus.size_i[1] && bus.addr_i[1:0] != 2'd0);
`else
    assign w_mis = 1'b0;
`endif

    // Big-endian lanes: byte offset k lives (3-k)*8 bits up, and ~off == 3-off for 2 bits.
    assign w_sh    = {~r_addr[1:0], 3'b000};
    assign w_byte  = 8'(bus.ram_rdata_i >> w_sh);
    assign w_half  = r_addr[1] ? bus.ram_rdata_i[15:0] : bus.ram_rdata_i[31:16];
    assign w_bmask = 32'h0000_00FF << w_sh;
    assign w_load  = r_size[1] ? bus.ram_rdata_i :
                     r_size[0] ? {{16{~r_uns & w_half[15]}}, w_half} :
                                 {{24{~r_uns & w_byte[7]}}, w_byte};
    assign w_merge = r_size[0] ? (r_addr[1] ? {bus.ram_rdata_i[31:16], r_wdata[15:0]}
                                            : {r_wdata[15:0], bus.ram_rdata_i[15:0]})
                               : (bus.ram_rdata_i & ~w_bmask) | ({24'd0, r_wdata[7:0]} << w_sh);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= 32'd0;
            r_we    <= 1'b0;
            r_size  <= 2'd0;
            r_uns   <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.req_i && w_mis) begin
                        r_ack <= 1'b1;
                        r_err <= 1'b1;
                    end else if (bus.req_i) begin
                        r_we    <= bus.we_i;
                        r_size  <= bus.size_i;
                        r_uns   <= bus.unsigned_i;
                        r_addr  <= bus.addr_i;
                        r_wdata <= bus.wdata_i;
                        r_state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!r_we) begin
                        r_rdata <= w_load;
                        r_ack   <= 1'b1;
                        r_state <= IDLE;
                    end else if (r_size[1]) begin
                        r_ack   <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        // r_wdata is reused to hold the merged word for the WRITE cycle
                        r_wdata <= w_merge;
                        r_state <= WRITE;
                    end
                end
                WRITE: begin
                    r_ack   <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // RAM controls decode straight from the state register so reset removes them at once.
    assign bus.busy_o      = r_state != IDLE;
    assign bus.ram_ce_o    = r_state != IDLE;
    assign bus.ram_we_o    = (r_state == ACCESS && r_we && r_size[1]) || r_state == WRITE;
    assign bus.ram_addr_o  = r_addr & L_ADDR_MASK & 32'hFFFF_FFFC;
    assign bus.ram_wdata_o = r_wdata;
    assign bus.ack_o       = r_ack;
    assign bus.err_o       = r_err;
    assign bus.rdata_o     = r_rdata;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed scoreboard bench for mem_access_ctrl with a word RAM model
module tb_mem_access_ctrl;
    typedef struct {
        logic [31:0] rd;
        logic        err;
        logic        chk_rd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] mem [0:255];
    exp_t        sb [$];
    int          checks = 0;
    int          errors = 0;
    int          we_cnt = 0;
    int          ce_cnt = 0;
    logic [31:0] last_rd = 32'd0;

    mem_access_ctrl_if ifc ();

    mem_access_ctrl #(.RAM_ADDR_WIDTH(16)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (ifc)
    );

    always #5 clk = ~clk;

    assign ifc.ram_rdata_i = mem[ifc.ram_addr_o[9:2]];

    always @(posedge clk)
        if (ifc.ram_ce_o && ifc.ram_we_o) mem[ifc.ram_addr_o[9:2]] <= ifc.ram_wdata_o;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        we_cnt += int'(ifc.ram_we_o);
        ce_cnt += int'(ifc.ram_ce_o);
        if (rst_n && ifc.ack_o) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                if (e.chk_rd) chk("sb_rdata", ifc.rdata_o, e.rd);
                chk("sb_err", 32'(ifc.err_o), 32'(e.err));
            end
        end
    end

    // Called at a negedge; drives one request and returns at the negedge of its ack cycle.
    task automatic do_req(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp_rd,
                          input logic exp_err, input int lat);
        int n;
        ifc.req_i = 1'b1;
        ifc.we_i = we;
        ifc.size_i = sz;
        ifc.unsigned_i = uns;
        ifc.addr_i = a;
        ifc.wdata_i = wd;
        sb.push_back('{exp_rd, exp_err, !we && !exp_err});
        if (!we && !exp_err) last_rd = exp_rd;
        @(posedge clk);
        @(negedge clk);
        ifc.req_i = 1'b0;
        chk({tag, "_ce_c1"}, 32'(ifc.ram_ce_o), 32'(lat > 1));
        if (lat > 1) chk({tag, "_addr_c1"}, ifc.ram_addr_o, a & 32'h0000_FFFC);
        n = 1;
        while (!ifc.ack_o && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'(lat));
    endtask

    initial begin
        int w0;
        int c0;
        ifc.req_i = 1'b0;
        ifc.we_i = 1'b0;
        ifc.size_i = 2'd0;
        ifc.unsigned_i = 1'b0;
        ifc.addr_i = 32'd0;
        ifc.wdata_i = 32'd0;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[4]  = 32'h1122_3344;
        mem[8]  = 32'h80FF_7F01;
        mem[12] = 32'hAABB_CCDD;
        mem[20] = 32'h0102_0304;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(ifc.busy_o), 32'd0);
        chk("rst_ack", 32'(ifc.ack_o), 32'd0);
        chk("rst_err", 32'(ifc.err_o), 32'd0);
        chk("rst_rdata", ifc.rdata_o, 32'd0);
        chk("rst_ce", 32'(ifc.ram_ce_o), 32'd0);
        chk("rst_we", 32'(ifc.ram_we_o), 32'd0);
        chk("rst_addr", ifc.ram_addr_o, 32'd0);
        chk("rst_wdata", ifc.ram_wdata_o, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        do_req("lb11", 1'b0, 2'd0, 1'b0, 32'h11, 32'd0, 32'h0000_0022, 1'b0, 2);
        do_req("lh20s", 1'b0, 2'd1, 1'b0, 32'h20, 32'd0, 32'hFFFF_80FF, 1'b0, 2);
        do_req("lh22u", 1'b0, 2'd1, 1'b1, 32'h22, 32'd0, 32'h0000_7F01, 1'b0, 2);
        do_req("lb20s", 1'b0, 2'd0, 1'b0, 32'h20, 32'd0, 32'hFFFF_FF80, 1'b0, 2);
        do_req("lb21u", 1'b0, 2'd0, 1'b1, 32'h21, 32'd0, 32'h0000_00FF, 1'b0, 2);
        do_req("lb21s", 1'b0, 2'd0, 1'b0, 32'h21, 32'd0, 32'hFFFF_FFFF, 1'b0, 2);
        do_req("lb23s", 1'b0, 2'd0, 1'b0, 32'h23, 32'd0, 32'h0000_0001, 1'b0, 2);
        do_req("lw_hi", 1'b0, 2'd3, 1'b1, 32'h0001_0010, 32'd0, 32'h1122_3344, 1'b0, 2);
        w0 = we_cnt;
        do_req("sb33", 1'b1, 2'd0, 1'b0, 32'h33, 32'h1234_5678, last_rd, 1'b0, 3);
        chk("sb33_we_pulses", 32'(we_cnt - w0), 32'd1);
        chk("sb33_mem", mem[12], 32'hAABB_CC78);
        do_req("sh30", 1'b1, 2'd1, 1'b0, 32'h30, 32'h9999_ABCD, last_rd, 1'b0, 3);
        chk("sh30_mem", mem[12], 32'hABCD_CC78);
        w0 = we_cnt;
        do_req("sw40", 1'b1, 2'd2, 1'b0, 32'h40, 32'hDEAD_BEEF, last_rd, 1'b0, 2);
        do_req("lw40", 1'b0, 2'd2, 1'b0, 32'h40, 32'd0, 32'hDEAD_BEEF, 1'b0, 2);
        chk("sw40_we_pulses", 32'(we_cnt - w0), 32'd1);
        c0 = ce_cnt;
`ifdef MEMCTRL_MISALIGN_TRAP_EN
        do_req("lw42", 1'b0, 2'd2, 1'b0, 32'h42, 32'd0, 32'd0, 1'b1, 1);
        chk("lw42_no_ce", 32'(ce_cnt - c0), 32'd0);
        do_req("lh21", 1'b0, 2'd1, 1'b0, 32'h21, 32'd0, 32'd0, 1'b1, 1);
`else
        do_req("lw42", 1'b0, 2'd2, 1'b0, 32'h42, 32'd0, 32'hDEAD_BEEF, 1'b0, 2);
        chk("lw42_ce", 32'(ce_cnt - c0), 32'd1);
        do_req("lh21", 1'b0, 2'd1, 1'b0, 32'h21, 32'd0, 32'hFFFF_80FF, 1'b0, 2);
`endif
        @(negedge clk);
        chk("rdata_hold", ifc.rdata_o, last_rd);
        ifc.req_i = 1'b1;
        ifc.we_i = 1'b1;
        ifc.size_i = 2'd1;
        ifc.unsigned_i = 1'b0;
        ifc.addr_i = 32'h50;
        ifc.wdata_i = 32'h0000_BEEF;
        @(posedge clk);
        @(negedge clk);
        ifc.req_i = 1'b0;
        @(posedge clk);
        #1;
        chk("rmw_write_we", 32'(ifc.ram_we_o), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rmw_rst_we", 32'(ifc.ram_we_o), 32'd0);
        chk("rmw_rst_ce", 32'(ifc.ram_ce_o), 32'd0);
        chk("rmw_rst_busy", 32'(ifc.busy_o), 32'd0);
        chk("rmw_rst_ack", 32'(ifc.ack_o), 32'd0);
        chk("rmw_rst_rdata", ifc.rdata_o, 32'd0);
        chk("rmw_rst_addr", ifc.ram_addr_o, 32'd0);
        chk("rmw_rst_wdata", ifc.ram_wdata_o, 32'd0);
        repeat (2) @(negedge clk);
        chk("rmw_mem_kept", mem[20], 32'h0102_0304);
        rst_n = 1'b1;
        last_rd = 32'd0;
        @(negedge clk);
        do_req("lh52u", 1'b0, 2'd1, 1'b1, 32'h52, 32'd0, 32'h0000_0304, 1'b0, 2);
        repeat (2) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Load/store controller between the core MEM stage and the data port of the dual-port RAM.
- The RAM port is word-only: combinational read, synchronous write on clk_i, byte 0 of each word in bits [31:24].
- This block implements byte/halfword/word loads with sign/zero extension, and byte/halfword stores by read-modify-write.
- Core sees a req/busy/ack handshake.

Parameters:
- RAM_ADDR_WIDTH, 16, number of byte-address bits forwarded to the RAM; upper address bits are forced to 0 on ram_addr_o.

Ports:
- clk_i  input  1  clock; all state updates on rising edge
- rst_ni  input  1  asynchronous active-low reset
- req_i  input  1  core access request, sampled only when busy_o=0
- we_i  input  1  1=store, 0=load
- size_i  input  2  0=byte, 1=half, 2=word, 3=reserved (treated as word)
- unsigned_i  input  1  load zero-extend when 1, sign-extend when 0
- addr_i  input  32  byte address
- wdata_i  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
- busy_o  output  1  combinational, 1 whenever state != IDLE
- ack_o  output  1  registered one-cycle completion pulse
- err_o  output  1  registered misalignment flag, valid with ack_o
- rdata_o  output  32  registered load result, held until next load completes
- ram_ce_o  output  1  RAM chip enable
- ram_we_o  output  1  RAM write enable
- ram_addr_o  output  32  word-aligned RAM address ([1:0]=0)
- ram_wdata_o  output  32  RAM write data
- ram_rdata_i  input  32  RAM combinational read data

Behaviour:
- Reset (async, rst_ni=0): state=IDLE; ack_o=0, err_o=0, rdata_o=0; ram_ce_o=0, ram_we_o=0, ram_addr_o=0, ram_wdata_o=0.
- Reset takes effect immediately, including mid-RMW: no write is issued after reset assertion.
- States: IDLE, ACCESS, WRITE.
- IDLE:
  - ram_ce_o=0, ram_we_o=0.
  - req_i=1 latches we, size, unsigned, addr, wdata and moves to ACCESS.
  - Misaligned request (see Optional Feature): stay in IDLE; next cycle ack_o=1, err_o=1; no RAM access.
- ACCESS:
  - ram_ce_o=1; ram_addr_o = latched addr with [1:0] cleared.
  - Load: extract the lane from ram_rdata_i, extend it, register into rdata_o; ack_o=1 next cycle; go to IDLE.
  - Word store: ram_we_o=1, ram_wdata_o=wdata; ack_o=1 next cycle; go to IDLE.
  - Byte/half store: capture ram_rdata_i, merge the new lane; go to WRITE.
- WRITE:
  - ram_ce_o=1, ram_we_o=1, ram_wdata_o=merged word; ack_o=1 next cycle; go to IDLE.
- Latency (request accepted in cycle 0):
  - Load and word store: ack_o in cycle 2.
  - Byte/half store: ack_o in cycle 3.
  - A back-to-back request can be accepted in the ack_o cycle.
- req_i while busy_o=1 is ignored; the core must hold req_i until busy_o=0.
- Lane map (big-endian):
  - byte offset 0 -> [31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0].
  - half offset 0 -> [31:16], offset 2 -> [15:0].
- Extension: sign bit is the lane MSB; unsigned_i is ignored for word loads.
- ack_o and err_o are single-cycle pulses. err_o=0 on every non-error ack.
- A store never modifies rdata_o.

Optional Feature:
- Macro: MEMCTRL_MISALIGN_TRAP_EN.
- Defined: a half access with addr[0]=1, or a word access with addr[1:0]!=0, is misaligned and completes as an error per IDLE above.
- Undefined: no misalignment check and err_o is tied 0.
  - Half uses addr[1] only; word ignores addr[1:0].
  - Access proceeds normally with the low bits ignored.

Test Plan:
- RAM word@0x10=0x11223344; load byte addr 0x11, unsigned_i=0 -> ack_o in cycle 2, rdata_o=0x00000022.
- RAM word@0x20=0x80FF7F01; load half 0x20 signed -> rdata_o=0xFFFF80FF; load half 0x22 unsigned -> rdata_o=0x00007F01.
- RAM word@0x30=0xAABBCCDD; store byte 0x33, wdata_i=0x12345678 -> ram_we_o high exactly 1 cycle (cycle 2), word becomes 0xAABBCC78, ack_o in cycle 3.
- Store word 0x40 = 0xDEADBEEF, then immediate load word 0x40 in the ack cycle -> rdata_o=0xDEADBEEF, one ram_we_o pulse total.
- With MEMCTRL_MISALIGN_TRAP_EN: load word addr 0x42 -> ack_o=1 and err_o=1 in cycle 1, ram_ce_o never 1. Without the macro: same request returns word@0x40, err_o=0.
- Half store to 0x50 (RAM word=0x01020304); assert rst_ni=0 during WRITE state -> ram_we_o drops immediately, word still 0x01020304, all outputs 0, state IDLE.
